// File: rtl/tone_pkg.sv
// Shared tone codes, FSM state encoding and the divider/window arithmetic
// used to classify measured half-periods.
package tone_pkg;

  localparam logic [2:0] CODE_ITEM0 = 3'd0;
  localparam logic [2:0] CODE_ITEM1 = 3'd1;
  localparam logic [2:0] CODE_ITEM2 = 3'd2;
  localparam logic [2:0] CODE_ITEM3 = 3'd3;
  localparam logic [2:0] CODE_ERROR = 3'd4;
  localparam logic [2:0] CODE_NONE  = 3'd7;

  localparam int NUM_CLASSES = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Nominal half-period, in clk cycles, of a square wave at freq_hz.
  function automatic logic [31:0] half_period_div(input longint clock_hz, input longint freq_hz);
    return 32'(clock_hz / (2 * freq_hz));
  endfunction

  // Scales a divider by pct percent (integer, truncating) to form a window bound.
  function automatic logic [31:0] window_bound(input logic [31:0] div, input longint pct);
    return 32'((longint'(div) * pct) / 100);
  endfunction

endpackage

// File: rtl/audio_sync_edge.sv
// Two-flop synchroniser for the asynchronous audio input followed by a
// registered both-edge strobe; the strobe rises 3 clk after an input transition.
module audio_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic audio_in,
  output logic edge_stb
);

  logic [1:0] sync_reg;
  logic       prev_reg;
  logic       edge_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b00;
      prev_reg <= 1'b0;
      edge_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], audio_in};
      prev_reg <= sync_reg[1];
      edge_reg <= sync_reg[1] ^ prev_reg;
    end
  end

  assign edge_stb = edge_reg;

endmodule

// File: rtl/tone_decoder.sv
// Vend/error tone decoder: measures audio half-periods, locks onto a class after
// CONFIRM_EDGES consistent half-periods and reports each tone's duration at its end.
module tone_decoder
  import tone_pkg::*;
#(
  parameter int CLOCK_HZ      = 100_000_000,
  parameter int ITEM0_FREQ_HZ = 800,
  parameter int ITEM1_FREQ_HZ = 1000,
  parameter int ITEM2_FREQ_HZ = 1200,
  parameter int ITEM3_FREQ_HZ = 1400,
  parameter int ERROR_FREQ_HZ = 300,
  parameter int TOL_PCT       = 5,
  parameter int CONFIRM_EDGES = 4,
  parameter int MIN_TONE_MS   = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        audio_in,
  output logic        tone_locked,
  output logic [2:0]  tone_code,
  output logic        tone_valid,
  output logic [15:0] tone_ms,
  output logic        tone_short
);

  localparam logic [31:0] SILENCE_CYCLES =
    half_period_div(longint'(CLOCK_HZ), longint'(ERROR_FREQ_HZ)) << 1;
  localparam logic [31:0] PRESCALE_MAX = 32'(CLOCK_HZ / 1000 - 1);
  localparam logic [7:0]  CONFIRM      = 8'(CONFIRM_EDGES);
  localparam logic [15:0] MIN_MS       = 16'(MIN_TONE_MS);

  logic                   edge_stb;
  logic                   timeout;
  logic [31:0]            hp_cnt_reg;
  logic [NUM_CLASSES-1:0] hit;
  logic [2:0]             class_code [NUM_CLASSES];
  logic [2:0]             edge_class;

  state_t      state_reg, state_next;
  logic [2:0]  cand_reg, cand_next;
  logic [7:0]  match_reg, match_next;
  logic [2:0]  code_reg;
  logic [31:0] presc_reg;
  logic [15:0] ms_reg, ms_at_edge_reg, tone_ms_reg, end_ms;
  logic        valid_reg, short_reg;
  logic        start_measure, tone_end, end_on_edge, lock_now;

  audio_sync_edge u_sync (
    .clk      (clk),
    .rst      (rst),
    .audio_in (audio_in),
    .edge_stb (edge_stb)
  );

  // On a strobe hp_cnt_reg holds the exact clk count since the previous strobe.
  for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_class
    localparam int FREQ = (gi == 0) ? ITEM0_FREQ_HZ : (gi == 1) ? ITEM1_FREQ_HZ :
                          (gi == 2) ? ITEM2_FREQ_HZ : (gi == 3) ? ITEM3_FREQ_HZ : ERROR_FREQ_HZ;
    localparam logic [2:0]  CODE = (gi == 0) ? CODE_ITEM0 : (gi == 1) ? CODE_ITEM1 :
                                   (gi == 2) ? CODE_ITEM2 : (gi == 3) ? CODE_ITEM3 : CODE_ERROR;
    localparam logic [31:0] DIV  = half_period_div(longint'(CLOCK_HZ), longint'(FREQ));
    localparam logic [31:0] LO   = window_bound(DIV, longint'(100 - TOL_PCT));
    localparam logic [31:0] HI   = window_bound(DIV, longint'(100 + TOL_PCT));
    assign hit[gi]        = (hp_cnt_reg >= LO) && (hp_cnt_reg <= HI);
    assign class_code[gi] = CODE;
  end

  always_comb begin
    edge_class = CODE_NONE;
    for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
      if (hit[i]) edge_class = class_code[i];
    end
  end

  assign timeout = !edge_stb && (hp_cnt_reg >= SILENCE_CYCLES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cand_reg  <= CODE_NONE;
      match_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      cand_reg  <= cand_next;
      match_reg <= match_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cand_next     = cand_reg;
    match_next    = match_reg;
    start_measure = 1'b0;
    tone_end      = 1'b0;
    end_on_edge   = 1'b0;
    lock_now      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (edge_stb) begin
          state_next    = ST_MEASURE;
          start_measure = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (edge_stb) begin
          if (edge_class == CODE_NONE) begin
            match_next = 8'd0;
          end else if (edge_class == cand_reg) begin
            match_next = (match_reg != 8'hFF) ? match_reg + 8'd1 : match_reg;
          end else begin
            cand_next  = edge_class;
            match_next = 8'd1;
          end
          if (edge_class != CODE_NONE && match_next >= CONFIRM) begin
            state_next = ST_LOCKED;
            lock_now   = 1'b1;
          end
        end else if (timeout) begin
          state_next = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (edge_stb) begin
          if (edge_class != code_reg) begin
            tone_end      = 1'b1;
            end_on_edge   = 1'b1;
            start_measure = 1'b1;
            state_next    = ST_MEASURE;
          end
        end else if (timeout) begin
          tone_end   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (start_measure) begin
      cand_next  = CODE_NONE;
      match_next = 8'd0;
    end
  end

  // A silence-terminated tone ends at its last edge, so the trailing gap is excluded.
  assign end_ms = end_on_edge ? ms_reg : ms_at_edge_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hp_cnt_reg     <= 32'd0;
      presc_reg      <= 32'd0;
      ms_reg         <= 16'd0;
      ms_at_edge_reg <= 16'd0;
      code_reg       <= CODE_NONE;
      valid_reg      <= 1'b0;
      tone_ms_reg    <= 16'd0;
      short_reg      <= 1'b0;
    end else begin
      if (edge_stb)                  hp_cnt_reg <= 32'd1;
      else if (hp_cnt_reg != '1)     hp_cnt_reg <= hp_cnt_reg + 32'd1;

      if (start_measure) begin
        presc_reg      <= 32'd0;
        ms_reg         <= 16'd0;
        ms_at_edge_reg <= 16'd0;
      end else if (state_reg != ST_IDLE) begin
        if (presc_reg == PRESCALE_MAX) begin
          presc_reg <= 32'd0;
          if (ms_reg != 16'hFFFF) ms_reg <= ms_reg + 16'd1;
        end else begin
          presc_reg <= presc_reg + 32'd1;
        end
        if (edge_stb) ms_at_edge_reg <= ms_reg;
      end

      if (lock_now) code_reg <= cand_next;
      valid_reg <= tone_end;
      if (tone_end) begin
        tone_ms_reg <= end_ms;
        short_reg   <= (end_ms < MIN_MS);
      end
    end
  end

  always_comb begin
    tone_locked = (state_reg == ST_LOCKED);
    tone_code   = code_reg;
    tone_valid  = valid_reg;
    tone_ms     = tone_ms_reg;
    tone_short  = short_reg;
  end

endmodule
